// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the fetch/data memory port arbiter.
// The response-owner encoding lives here so testbenches can name the states.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around the memory port arbiter.
// master = requesters plus RAM model; slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              flush;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, flush,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, flush,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a data port.
// Data wins by default; a fetch starved for STARVE_LIMIT data grants gets one slot.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                sysclk,
    input  logic                cpu_reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                flush,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    owner_t           resp_owner_q, resp_owner_d;
    logic             fetch_win;

    // Byte offset bits are irrelevant to a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // Grant and RAM drive, purely from this cycle's requests.
    always_comb begin
        fetch_win = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!cpu_reset) begin
            fetch_win = if_req && !flush && (!d_req || (starve_cnt_q >= LIMIT_C));
            if_gnt    = fetch_win;
            d_gnt     = d_req && !fetch_win;
        end
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_W-1:2];
        end else if (d_gnt) begin
            mem_en   = 1'b1;
            mem_addr = d_addr[ADDR_W-1:2];
            if (d_we) begin
                mem_we    = d_be;
                mem_wdata = d_wdata;
            end
        end
    end

    // Counts data wins while a fetch sits waiting; saturates if flush keeps fetch out.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q < LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Records who owns the RAM read data returning next cycle.
    always_comb begin
        resp_owner_d = NONE;
        if (if_gnt) begin
            resp_owner_d = FETCH;
        end else if (d_gnt && !d_we) begin
            resp_owner_d = DATA;
        end
    end

    always_comb begin
        if_rvalid = (resp_owner_q == FETCH) && !flush && !cpu_reset;
        d_rvalid  = (resp_owner_q == DATA) && !cpu_reset;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge sysclk or posedge cpu_reset) begin
        if (cpu_reset) begin
            starve_cnt_q <= '0;
            resp_owner_q <= NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_owner_q <= resp_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256-word, 1-cycle-latency RAM model.
// RAM word i is preloaded with 0x5A000000 | i.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic sysclk;
    logic cpu_reset;
    int   vec;
    int   errs;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .sysclk    (sysclk),
        .cpu_reset (cpu_reset),
        .if_req    (bus.if_req),
        .if_addr   (bus.if_addr),
        .if_gnt    (bus.if_gnt),
        .if_rvalid (bus.if_rvalid),
        .if_rdata  (bus.if_rdata),
        .flush     (bus.flush),
        .d_req     (bus.d_req),
        .d_we      (bus.d_we),
        .d_be      (bus.d_be),
        .d_addr    (bus.d_addr),
        .d_wdata   (bus.d_wdata),
        .d_gnt     (bus.d_gnt),
        .d_rvalid  (bus.d_rvalid),
        .d_rdata   (bus.d_rdata),
        .mem_en    (bus.mem_en),
        .mem_we    (bus.mem_we),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata),
        .mem_rdata (bus.mem_rdata)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic [31:0] ram [256];
    logic [31:0] ram_rd_q;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h5A00_0000 | i;
        ram_rd_q = '0;
    end

    always @(posedge sysclk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            ram_rd_q <= ram[bus.mem_addr[7:0]];
        end
    end
    assign bus.mem_rdata = ram_rd_q;

    task automatic next_cycle();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.flush   = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        cpu_reset   = 1'b1;
        idle_inputs();
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_be    = 4'hF;
        bus.d_we    = 1'b1;
        @(negedge sysclk);
        vec++; if (bus.if_gnt !== 1'b0) begin errs++; $display("FAIL rst_if_gnt got %b want 0", bus.if_gnt); end
        vec++; if (bus.d_gnt !== 1'b0) begin errs++; $display("FAIL rst_d_gnt got %b want 0", bus.d_gnt); end
        vec++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got %b want 0", bus.mem_en); end
        vec++; if (bus.mem_we !== 4'h0) begin errs++; $display("FAIL rst_mem_we got %h want 0", bus.mem_we); end
        vec++; if ({bus.if_rvalid, bus.d_rvalid} !== 2'b00) begin errs++; $display("FAIL rst_rvalid got %b want 00", {bus.if_rvalid, bus.d_rvalid}); end
        next_cycle();
        idle_inputs();
        cpu_reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge sysclk);
        vec++; if (bus.if_gnt !== 1'b1) begin errs++; $display("FAIL fo_if_gnt got %b want 1", bus.if_gnt); end
        vec++; if (bus.d_gnt !== 1'b0) begin errs++; $display("FAIL fo_d_gnt got %b want 0", bus.d_gnt); end
        vec++; if (bus.mem_addr !== 30'h40) begin errs++; $display("FAIL fo_mem_addr got %h want 40", bus.mem_addr); end
        vec++; if (bus.mem_we !== 4'h0) begin errs++; $display("FAIL fo_mem_we got %h want 0", bus.mem_we); end
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge sysclk);
        vec++; if (bus.if_rvalid !== 1'b1) begin errs++; $display("FAIL fo_rvalid got %b want 1", bus.if_rvalid); end
        vec++; if (bus.if_rdata !== 32'h5A00_0040) begin errs++; $display("FAIL fo_rdata got %h want 5a000040", bus.if_rdata); end
        next_cycle();
        @(negedge sysclk);
        vec++; if (bus.if_rvalid !== 1'b0) begin errs++; $display("FAIL fo_rvalid_off got %b want 0", bus.if_rvalid); end
        vec++; if (bus.if_rdata !== 32'h0) begin errs++; $display("FAIL fo_rdata_zero got %h want 0", bus.if_rdata); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h200;
        @(negedge sysclk);
        vec++; if ({bus.d_gnt, bus.if_gnt} !== 2'b10) begin errs++; $display("FAIL sim_gnt got %b want 10", {bus.d_gnt, bus.if_gnt}); end
        vec++; if (bus.mem_addr !== 30'h80) begin errs++; $display("FAIL sim_mem_addr got %h want 80", bus.mem_addr); end
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge sysclk);
        vec++; if (bus.d_rvalid !== 1'b1) begin errs++; $display("FAIL sim_d_rvalid got %b want 1", bus.d_rvalid); end
        vec++; if (bus.d_rdata !== 32'h5A00_0080) begin errs++; $display("FAIL sim_d_rdata got %h want 5a000080", bus.d_rdata); end
        vec++; if (bus.if_gnt !== 1'b1) begin errs++; $display("FAIL sim_if_gnt got %b want 1", bus.if_gnt); end
        vec++; if (bus.mem_addr !== 30'h41) begin errs++; $display("FAIL sim_if_addr got %h want 41", bus.mem_addr); end
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge sysclk);
        vec++; if (bus.if_rvalid !== 1'b1) begin errs++; $display("FAIL sim_if_rvalid got %b want 1", bus.if_rvalid); end
        vec++; if (bus.if_rdata !== 32'h5A00_0041) begin errs++; $display("FAIL sim_if_rdata got %h want 5a000041", bus.if_rdata); end
        vec++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL sim_d_rvalid_off got %b want 0", bus.d_rvalid); end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit want_d;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h10;
        for (int i = 0; i < 10; i++) begin
            want_d = (i % 5) != 4;
            @(negedge sysclk);
            vec++;
            if ({bus.d_gnt, bus.if_gnt} !== {want_d, !want_d}) begin
                errs++;
                $display("FAIL starve_c%0d got d/if %b want %b", i, {bus.d_gnt, bus.if_gnt}, {want_d, !want_d});
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_write_read();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0011;
        bus.d_addr  = 32'h8;
        bus.d_wdata = 32'hAABB_CCDD;
        @(negedge sysclk);
        vec++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL wr_d_gnt got %b want 1", bus.d_gnt); end
        vec++; if (bus.mem_we !== 4'b0011) begin errs++; $display("FAIL wr_mem_we got %b want 0011", bus.mem_we); end
        vec++; if (bus.mem_wdata !== 32'hAABB_CCDD) begin errs++; $display("FAIL wr_wdata got %h want aabbccdd", bus.mem_wdata); end
        vec++; if (bus.mem_addr !== 30'h2) begin errs++; $display("FAIL wr_mem_addr got %h want 2", bus.mem_addr); end
        next_cycle();
        bus.d_we = 1'b0;
        bus.d_be = 4'b0000;
        @(negedge sysclk);
        vec++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL wr_no_rvalid got %b want 0", bus.d_rvalid); end
        vec++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL rd_d_gnt got %b want 1", bus.d_gnt); end
        vec++; if (bus.mem_we !== 4'h0) begin errs++; $display("FAIL rd_mem_we got %b want 0000", bus.mem_we); end
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge sysclk);
        vec++; if (bus.d_rvalid !== 1'b1) begin errs++; $display("FAIL rd_d_rvalid got %b want 1", bus.d_rvalid); end
        vec++; if (bus.d_rdata !== 32'h5A00_CCDD) begin errs++; $display("FAIL rd_d_rdata got %h want 5a00ccdd", bus.d_rdata); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_flush();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge sysclk);
        vec++; if (bus.if_gnt !== 1'b1) begin errs++; $display("FAIL fl_if_gnt got %b want 1", bus.if_gnt); end
        next_cycle();
        bus.flush = 1'b1;
        @(negedge sysclk);
        vec++; if (bus.if_rvalid !== 1'b0) begin errs++; $display("FAIL fl_rvalid got %b want 0", bus.if_rvalid); end
        vec++; if (bus.if_rdata !== 32'h0) begin errs++; $display("FAIL fl_rdata got %h want 0", bus.if_rdata); end
        vec++; if (bus.if_gnt !== 1'b0) begin errs++; $display("FAIL fl_no_gnt got %b want 0", bus.if_gnt); end
        vec++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL fl_mem_en got %b want 0", bus.mem_en); end
        next_cycle();
        idle_inputs();
        @(negedge sysclk);
        vec++; if (bus.if_rvalid !== 1'b0) begin errs++; $display("FAIL fl_after got %b want 0", bus.if_rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h200;
        @(negedge sysclk);
        vec++; if (bus.d_gnt !== 1'b1) begin errs++; $display("FAIL rm_d_gnt got %b want 1", bus.d_gnt); end
        next_cycle();
        cpu_reset = 1'b1;
        idle_inputs();
        @(negedge sysclk);
        vec++; if (bus.d_rvalid !== 1'b0) begin errs++; $display("FAIL rm_d_rvalid got %b want 0", bus.d_rvalid); end
        vec++; if (bus.d_rdata !== 32'h0) begin errs++; $display("FAIL rm_d_rdata got %h want 0", bus.d_rdata); end
        vec++; if (dut.starve_cnt_q !== 3'd0) begin errs++; $display("FAIL rm_starve got %0d want 0", dut.starve_cnt_q); end
        next_cycle();
        cpu_reset = 1'b0;
        @(negedge sysclk);
        vec++; if ({bus.if_gnt, bus.d_gnt, bus.mem_en} !== 3'b000) begin errs++; $display("FAIL rm_post_gnt got %b want 000", {bus.if_gnt, bus.d_gnt, bus.mem_en}); end
        vec++; if ({bus.if_rvalid, bus.d_rvalid} !== 2'b00) begin errs++; $display("FAIL rm_post_rvalid got %b want 00", {bus.if_rvalid, bus.d_rvalid}); end
        vec++; if (bus.mem_we !== 4'h0) begin errs++; $display("FAIL rm_post_we got %h want 0", bus.mem_we); end
        vec++; if (dut.starve_cnt_q !== 3'd0) begin errs++; $display("FAIL rm_post_starve got %0d want 0", dut.starve_cnt_q); end
        next_cycle();
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_write_read();
        test_flush();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
